// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types, default sizing and the anode one-hot helper
//               for the segment scan multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef logic [3:0] nibble_t;

    localparam int c_DEF_NUM_DIGITS  = 8;
    localparam int c_DEF_REFRESH_DIV = 100000;
    localparam int c_DEF_GUARD       = 2;
    localparam int c_MAX_DIGITS      = 64;

    // Callers slice the low NUM_DIGITS bits; NUM_DIGITS must stay below c_MAX_DIGITS.
    function automatic logic [c_MAX_DIGITS-1:0] onehot_n(input int unsigned idx);
        return ~(c_MAX_DIGITS'(1) << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux_if
// Description : Valid/ready load port carrying a packed display word.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_mux_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = c_DEF_NUM_DIGITS
);
    logic                    data_valid;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    data_ready;

    modport master (output data_valid, output data_in, input  data_ready);
    modport slave  (input  data_valid, input  data_in, output data_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux_refresh_divider.sv
`default_nettype none
// ============================================================================
// Module      : refresh_divider
// Description : Dwell counter, digit index sequencing, guard window and the
//               end-of-frame pulse for the scan multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_divider #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8,
    parameter int GUARD       = 2
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    output      logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output      logic                          frame_tick,
    output      logic [$clog2(NUM_DIGITS)-1:0] idx_next,
    output      logic                          guard_next
);
    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    logic [c_CNT_W-1:0] r_div;
    logic [c_CNT_W-1:0] w_div_next;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_frame;
    logic               w_dwell_end;
    logic               w_frame_next;

    // Next-state values are exported so the parent can register outputs that
    // line up with the counter on the same cycle.
    always_comb begin
        w_dwell_end = (r_div == c_DIV_LAST);
        w_div_next  = w_dwell_end ? '0 : r_div + c_CNT_W'(1);
        idx_next    = r_idx;
        if (w_dwell_end) begin
            idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end
        w_frame_next = (w_div_next == c_DIV_LAST) && (idx_next == c_IDX_LAST);
    end

    generate
        if (GUARD > 0) begin : g_guard
            assign guard_next = (w_div_next < c_CNT_W'(GUARD));
        end else begin : g_no_guard
            assign guard_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_div   <= w_div_next;
            r_idx   <= idx_next;
            r_frame <= w_frame_next;
        end
    end

    assign digit_idx  = r_idx;
    assign frame_tick = r_frame;

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Multi-digit display scanner with frame-aligned word updates
//               feeding a 4-bit to 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = c_DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = c_DEF_REFRESH_DIV,
    parameter int GUARD       = c_DEF_GUARD
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    seg_scan_mux_if.slave                      bus,
    input  wire logic [NUM_DIGITS-1:0]         blank_mask,
    output      nibble_t                       nibble_out,
    output      logic [NUM_DIGITS-1:0]         anode_n,
    output      logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output      logic                          frame_tick
);
    localparam int c_WORD_W = 4 * NUM_DIGITS;
    localparam int c_IDX_W  = $clog2(NUM_DIGITS);

    logic [c_WORD_W-1:0]     r_active;
    logic [c_WORD_W-1:0]     r_pending;
    logic                    r_ready;
    nibble_t                 r_nibble;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic                    w_guard_next;
    logic                    w_commit;
    logic [c_WORD_W-1:0]     w_src;
    logic [c_MAX_DIGITS-1:0] w_sel_full;
    logic                    w_unused_sel;

    refresh_divider #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS),
        .GUARD       (GUARD)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick),
        .idx_next   (w_idx_next),
        .guard_next (w_guard_next)
    );

    // A full pending buffer is exactly r_ready low, so commit needs no extra flag.
    assign w_commit     = frame_tick & ~r_ready;
    assign w_src        = w_commit ? r_pending : r_active;
    assign w_sel_full   = onehot_n(32'(w_idx_next));
    assign w_unused_sel = &{1'b0, w_sel_full[c_MAX_DIGITS-1:NUM_DIGITS]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= '0;
            r_pending <= '0;
            r_ready   <= 1'b1;
            r_nibble  <= '0;
            r_anode   <= '1;
        end else begin
            // Accept and commit are exclusive: accept needs the buffer empty.
            if (w_commit) begin
                r_active <= r_pending;
                r_ready  <= 1'b1;
            end else if (bus.data_valid && r_ready) begin
                r_pending <= bus.data_in;
                r_ready   <= 1'b0;
            end
            r_nibble <= w_src[4*int'(w_idx_next) +: 4];
            if (w_guard_next || blank_mask[w_idx_next]) begin
                r_anode <= '1;
            end else begin
                r_anode <= w_sel_full[NUM_DIGITS-1:0];
            end
        end
    end

    assign bus.data_ready = r_ready;
    assign nibble_out     = r_nibble;
    assign anode_n        = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Self-checking bench for seg_scan_mux (4 digits, dwell 4, guard 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;
    import seg_pkg::*;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] blank_mask = '0;
    nibble_t    nibble_out;
    logic [3:0] anode_n;
    logic [1:0] digit_idx;
    logic       frame_tick;

    seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD       (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .blank_mask (blank_mask),
        .nibble_out (nibble_out),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: time since reset release plus the two word buffers.
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_full;
    logic [3:0]  m_anode;

    task automatic model_reset();
        m_t = 0; m_active = '0; m_pending = '0; m_full = 0; m_anode = 4'hF;
    endtask

    task automatic model_advance(input logic v, input logic [15:0] d, input logic [3:0] m);
        int k;
        if ((m_t % FRAME) == FRAME - 1 && m_full) begin
            m_active = m_pending;
            m_full   = 0;
        end else if (v && !m_full) begin
            m_pending = d;
            m_full    = 1;
        end
        m_t++;
        k = (m_t / R) % N;
        if ((m_t % R) < G || m[k]) m_anode = 4'hF;
        else                       m_anode = ~(4'b0001 << k);
    endtask

    task automatic check_model();
        int k;
        k = (m_t / R) % N;
        chk("anode",  anode_n,        m_anode);
        chk("nibble", nibble_out,     (m_active >> (4 * k)) & 16'hF);
        chk("ready",  bus.data_ready, !m_full);
        chk("idx",    digit_idx,      k);
        chk("tick",   frame_tick,     (m_t % FRAME) == FRAME - 1);
    endtask

    // Called at a falling edge: check cycle m_t, then drive inputs for it.
    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] m);
        check_model();
        bus.data_valid = v;
        bus.data_in    = d;
        blank_mask     = m;
        model_advance(v, d, m);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        blank_mask     = '0;
        rst_n          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] exp_anode;
        logic [1:0] exp_idx;
        logic       exp_tick;
    } vec_t;

    vec_t        tbl[18];
    logic [15:0] word;

    initial begin
        tbl[0]  = '{4'h0, 4'hF, 2'd0, 1'b0};
        tbl[1]  = '{4'h0, 4'hE, 2'd0, 1'b0};
        tbl[2]  = '{4'h0, 4'hE, 2'd0, 1'b0};
        tbl[3]  = '{4'h0, 4'hE, 2'd0, 1'b0};
        tbl[4]  = '{4'h0, 4'hF, 2'd1, 1'b0};
        tbl[5]  = '{4'h2, 4'hD, 2'd1, 1'b0};
        tbl[6]  = '{4'h0, 4'hF, 2'd1, 1'b0};
        tbl[7]  = '{4'h0, 4'hD, 2'd1, 1'b0};
        tbl[8]  = '{4'h0, 4'hF, 2'd2, 1'b0};
        tbl[9]  = '{4'h0, 4'hB, 2'd2, 1'b0};
        tbl[10] = '{4'h0, 4'hB, 2'd2, 1'b0};
        tbl[11] = '{4'h0, 4'hB, 2'd2, 1'b0};
        tbl[12] = '{4'h0, 4'hF, 2'd3, 1'b0};
        tbl[13] = '{4'h0, 4'h7, 2'd3, 1'b0};
        tbl[14] = '{4'h0, 4'h7, 2'd3, 1'b0};
        tbl[15] = '{4'h0, 4'h7, 2'd3, 1'b1};
        tbl[16] = '{4'h0, 4'hF, 2'd0, 1'b0};
        tbl[17] = '{4'h0, 4'hE, 2'd0, 1'b0};

        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        @(negedge clk);
        chk("rst_anode",  anode_n,        4'hF);
        chk("rst_nibble", nibble_out,     4'h0);
        chk("rst_ready",  bus.data_ready, 1'b1);
        chk("rst_idx",    digit_idx,      2'd0);
        chk("rst_tick",   frame_tick,     1'b0);

        // Scan timing with no load, including a one-cycle blank of digit 1.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            chk("tbl_anode",  anode_n,        tbl[i].exp_anode);
            chk("tbl_idx",    digit_idx,      tbl[i].exp_idx);
            chk("tbl_tick",   frame_tick,     tbl[i].exp_tick);
            chk("tbl_nibble", nibble_out,     4'h0);
            chk("tbl_ready",  bus.data_ready, 1'b1);
            blank_mask = tbl[i].mask;
            @(negedge clk);
        end

        // Load at cycle 2, held in pending until the frame boundary.
        do_reset();
        word = 16'h3A5C;
        for (int t = 0; t < 34; t++) begin
            if (t >= 3 && t <= 15) begin
                chk("load_ready_lo", bus.data_ready, 1'b0);
                chk("load_old_nib",  nibble_out,     4'h0);
            end
            if (t == 16) chk("load_ready_hi", bus.data_ready, 1'b1);
            if (t >= 16) chk("load_new_nib", nibble_out, word[4*((t/4)%4) +: 4]);
            step(t == 2, word, 4'h0);
        end

        // Back-pressure: the second word is dropped while ready is low.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if (t >= 16) chk("bp_nibble", nibble_out, 4'h1);
            step(t >= 2 && t <= 8, (t == 2) ? 16'h1111 : 16'h2222, 4'h0);
        end
        for (int t = 40; t < 80; t++) step(t == 40, 16'h2222, 4'h0);

        // Offer on a frame_tick cycle: commits one frame later.
        do_reset();
        for (int t = 0; t < 52; t++) begin
            if (t == 31) begin
                chk("sim_tick",  frame_tick,     1'b1);
                chk("sim_ready", bus.data_ready, 1'b1);
            end
            if (t == 32) chk("sim_old_d0",  nibble_out,     4'h4);
            if (t == 32) chk("sim_pending", bus.data_ready, 1'b0);
            if (t == 47) chk("sim_old_d3",  nibble_out,     4'h1);
            if (t == 48) chk("sim_new_d0",  nibble_out,     4'hF);
            if (t == 48) chk("sim_ready2",  bus.data_ready, 1'b1);
            step(t == 2 || t == 31, (t == 2) ? 16'h1234 : 16'hBEEF, 4'h0);
        end

        // Randomized traffic with an asynchronous reset in the middle.
        do_reset();
        begin
            logic [3:0] mask;
            mask = '0;
            for (int i = 0; i < 900; i++) begin
                if (i == 450) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("async_anode",  anode_n,        4'hF);
                    chk("async_nibble", nibble_out,     4'h0);
                    chk("async_ready",  bus.data_ready, 1'b1);
                    chk("async_idx",    digit_idx,      2'd0);
                    bus.data_valid = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    model_reset();
                end
                if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
                step($urandom_range(0, 5) == 0, 16'($urandom), mask);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
